// File: rtl/shift_engine_if.sv
// Command/status bundle for shift_engine: start handshake, operands,
// serial input and the register/progress outputs.
interface shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] load_data;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amount, load_data, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  start, op, amount, load_data, sin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_engine.sv
// Multi-mode shift register with a sequencer that applies a latched
// shift op once per clock for a programmed count, or does a parallel load.
//
//   state | meaning
//   IDLE  | waiting for start; LOAD/HOLD/zero-count complete here
//   SHIFT | applying op_r once per edge until cnt reaches terminal count
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  shift_engine_if.slave bus
);

  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_r, op_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             sout_r, sout_nxt;
  logic             done_r, done_nxt;

  logic [WIDTH-1:0] shift_q;
  logic             shift_out;
  logic             is_shift;

  assign is_shift = (bus.op >= OP_SHL) && (bus.op <= OP_ROR);

  always_comb begin
    shift_q   = q_r;
    shift_out = sout_r;
    case (op_r)
      OP_SHL: begin
        shift_q   = {q_r[WIDTH-2:0], bus.sin};
        shift_out = q_r[WIDTH-1];
      end
      OP_SHR: begin
        shift_q   = {bus.sin, q_r[WIDTH-1:1]};
        shift_out = q_r[0];
      end
      OP_ASR: begin
        shift_q   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        shift_out = q_r[0];
      end
      OP_ROL: begin
        shift_q   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        shift_out = q_r[WIDTH-1];
      end
      OP_ROR: begin
        shift_q   = {q_r[0], q_r[WIDTH-1:1]};
        shift_out = q_r[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    q_nxt     = q_r;
    sout_nxt  = sout_r;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_shift && (bus.amount != '0)) begin
            op_nxt    = bus.op;
            cnt_nxt   = bus.amount;
            state_nxt = SHIFT;
          end else begin
            // LOAD, HOLD, reserved and zero-count all finish on the accept edge
            done_nxt = 1'b1;
            if (bus.op == OP_LOAD) q_nxt = bus.load_data;
          end
        end
      end
      SHIFT: begin
        q_nxt    = shift_q;
        sout_nxt = shift_out;
        cnt_nxt  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      q_r    <= '0;
      sout_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op_r   <= op_nxt;
      q_r    <= q_nxt;
      sout_r <= sout_nxt;
      done_r <= done_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.sout = sout_r;
  assign bus.busy = (state == SHIFT);
  assign bus.done = done_r;

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine: a reference model computes the result of
// each command when it is driven; the entry is checked when done pulses.
module tb_shift_engine;

  logic clk;
  logic rst;

  shift_engine_if #(.WIDTH(8), .CNT_W(4)) bus ();

  shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       sout;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  m_q;
  logic        m_sout;
  logic [31:0] cur_pat;
  int          n_chk;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic [2:0] op, input int amt, input logic [7:0] data,
                           input logic [31:0] pat);
    exp_t e;
    int   lat;
    logic s;
    lat = 0;
    if (op >= 3'd1 && op <= 3'd5 && amt > 0) begin
      for (int i = 0; i < amt; i++) begin
        s = pat[i % 32];
        case (op)
          3'd1: begin m_sout = m_q[7]; m_q = {m_q[6:0], s}; end
          3'd2: begin m_sout = m_q[0]; m_q = {s, m_q[7:1]}; end
          3'd3: begin m_sout = m_q[0]; m_q = {m_q[7], m_q[7:1]}; end
          3'd4: begin m_sout = m_q[7]; m_q = {m_q[6:0], m_q[7]}; end
          default: begin m_sout = m_q[0]; m_q = {m_q[0], m_q[7:1]}; end
        endcase
      end
      lat = amt;
    end else if (op == 3'b110) begin
      m_q = data;
    end
    e.q = m_q;
    e.sout = m_sout;
    e.lat = lat;
    sb.push_back(e);
    cur_pat       = pat;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.amount    = amt[3:0];
    bus.load_data = data;
    bus.sin       = pat[0];
  endtask

  // Called in the cycle where start is high; returns in the done cycle.
  task automatic finish_cmd(input string tag, input bit glitch);
    exp_t e;
    int   k;
    int   busy_cyc;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    busy_cyc = 0;
    while (!bus.done && k < 100) begin
      if (bus.busy) busy_cyc++;
      bus.sin = cur_pat[k % 32];
      if (glitch) begin
        if (k == 1) begin
          bus.start     = 1'b1;
          bus.op        = 3'b110;
          bus.load_data = 8'hFF;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_dbusy"}, {31'd0, bus.busy}, 32'd0);
    e = sb.pop_front();
    chk({tag, "_lat"}, k, e.lat);
    chk({tag, "_busy"}, busy_cyc, e.lat);
    chk({tag, "_q"}, {24'd0, bus.q}, {24'd0, e.q});
    chk({tag, "_sout"}, {31'd0, bus.sout}, {31'd0, e.sout});
  endtask

  task automatic idle_step(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input int amt,
                     input logic [7:0] data, input logic [31:0] pat);
    drive_cmd(op, amt, data, pat);
    finish_cmd(tag, 1'b0);
    idle_step(tag);
  endtask

  initial begin
    bit seen;
    n_chk = 0;
    n_err = 0;
    m_q = '0;
    m_sout = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = '0;
    bus.amount = '0;
    bus.load_data = '0;
    bus.sin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_q", {24'd0, bus.q}, 32'd0);
    chk("rst_sout", {31'd0, bus.sout}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);

    run("pre", 3'b110, 0, 8'h5A, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_q", {24'd0, bus.q}, 32'd0);
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_done", {31'd0, bus.done}, 32'd0);
    m_q = '0;
    m_sout = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run("load", 3'b110, 7, 8'hA5, 32'h0);
    run("ld81", 3'b110, 0, 8'h81, 32'h0);
    run("shl3", 3'b001, 3, 8'h00, 32'hFFFF_FFFF);
    run("ld90", 3'b110, 0, 8'h90, 32'h0);
    run("asr2", 3'b011, 2, 8'h00, 32'hFFFF_FFFF);
    run("ld01", 3'b110, 0, 8'h01, 32'h0);
    run("ror9", 3'b101, 9, 8'h00, 32'h0);
    run("ld00", 3'b110, 0, 8'h00, 32'h0);
    run("shr4", 3'b010, 4, 8'h00, 32'h0000_000D);

    run("ld3c", 3'b110, 0, 8'h3C, 32'h0);
    drive_cmd(3'b001, 5, 8'h00, 32'h0000_0005);
    finish_cmd("ignbusy", 1'b1);
    idle_step("ignbusy");

    run("shl0", 3'b001, 0, 8'h00, 32'hFFFF_FFFF);
    run("rsvd", 3'b111, 3, 8'h11, 32'hFFFF_FFFF);
    run("hold", 3'b000, 2, 8'h22, 32'hFFFF_FFFF);
    run("ldb6", 3'b110, 0, 8'hB6, 32'h0);
    run("rol12", 3'b100, 12, 8'h00, 32'h0);
    run("asr15", 3'b011, 15, 8'h00, 32'h0);

    drive_cmd(3'b110, 0, 8'hC3, 32'h0);
    finish_cmd("b2b0", 1'b0);
    drive_cmd(3'b100, 2, 8'h00, 32'h0);
    finish_cmd("b2b1", 1'b0);
    drive_cmd(3'b010, 3, 8'h00, 32'h0000_0002);
    finish_cmd("b2b2", 1'b0);
    idle_step("b2b2");

    run("ld77", 3'b110, 0, 8'h77, 32'h0);
    drive_cmd(3'b100, 6, 8'h00, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_q", {24'd0, bus.q}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    sb.delete();
    m_q = '0;
    m_sout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);

    run("post", 3'b110, 0, 8'h4E, 32'h0);
    run("ror3", 3'b101, 3, 8'h00, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
